pipe_addsub: RTL and testbench
==============================

Name: pipe_addsub

Overview:
- Parametrised, pipelined successor to the team's 4-bit ripple adder.
- WIDTH-bit add/subtract with carry/borrow-in, split into STAGES register-separated ripple slices.
- Result carries carry/borrow-out and signed-overflow flags.
- Valid/ready streaming handshake on both sides; sits between operand sources and the datapath result bus.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of STAGES, >= 2
STAGES, 4, pipeline depth = number of ripple slices; each slice is WIDTH/STAGES bits; >= 1

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand beat valid
in_ready  output  1  block accepts a beat this cycle
a  input  WIDTH  operand A (unsigned or two's complement)
b  input  WIDTH  operand B
d  input  1  carry-in (add) / borrow-in (sub)
sub  input  1  0 = add, 1 = subtract
out_valid  output  1  result beat valid
out_ready  input  1  downstream accepts result
s  output  WIDTH  sum/difference
o  output  1  carry-out (add) / borrow-out (sub)
ovf  output  1  signed two's-complement overflow

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits, operand skew registers, partial sums and carries clear to 0. out_valid=0, s=0, o=0, ovf=0 immediately. in_ready=1 once rst_n is high.
- Global advance: en = ~out_valid | out_ready; in_ready = en (combinational).
  - When en=1, every stage shifts one slot; a bubble enters stage 0 if in_valid=0.
  - When en=0, all registers hold and the output stays stable.
- Beat accepted when in_valid & in_ready.
- Latency: exactly STAGES cycles from accept to out_valid with no stall. Throughput: 1 beat/cycle. Strict order; no drops, no duplicates.
- Arithmetic:
  - b_eff = sub ? ~b : b; cin = sub ? ~d : d.
  - Slice k adds bits [k*W/S +: W/S] of a and b_eff plus the registered carry from slice k-1 (cin for k=0).
  - Upper operand slices are carried forward in skew registers; lower result slices are carried forward in deskew registers.
  - Add: {o,s} = a + b + d.
  - Sub: s = a - b - d mod 2^WIDTH; o = ~final_carry, so o=1 means borrow.
  - ovf = carry into MSB XOR carry out of MSB, evaluated in the last slice.
- sub and d are captured with the beat and travel with it; changing them between beats has no effect on in-flight beats.
- Result = exact bitwise equivalent of a single-cycle WIDTH-bit ripple add. A carry crossing every slice boundary (e.g. all-ones + 1) must propagate correctly.
- STAGES=1: single register stage, latency 1.
- Simultaneous in_valid, out_valid and out_ready=1: output beat leaves and new beat enters in the same cycle.
- Reset mid-operation: all in-flight beats are discarded; no partial result is ever presented.

Optional Feature:
- Macro: PIPE_ADDSUB_SATURATE_EN.
- When defined, signed saturation is applied at the output stage:
  - ovf=1 with MSB of operand A = 0 -> s = 2^(WIDTH-1)-1.
  - ovf=1 with MSB of operand A = 1 -> s = -2^(WIDTH-1).
  - o and ovf still report the raw, unsaturated result.
  - Operand A's MSB travels in the pipeline for this purpose.
- When undefined, s is the wrapped result and no extra register exists.

Test Plan:
1. WIDTH=16/STAGES=4: a=0x1234, b=0x4321, d=0, sub=0, out_ready=1 -> 4 cycles later out_valid=1, s=0x5555, o=0, ovf=0.
2. a=0xFFFF, b=0x0001, d=0, add -> s=0x0000, o=1, ovf=0; carry crosses all 3 slice boundaries. Also a=0xFFFF, b=0x0000, d=1 -> same result.
3. sub: a=0x0000, b=0x0001, d=0 -> s=0xFFFF, o=1, ovf=0. a=0x8000, b=0x0001 -> s=0x7FFF, o=0, ovf=1.
4. a=0x7FFF, b=0x0001, add -> ovf=1; s=0x8000 without macro, s=0x7FFF with PIPE_ADDSUB_SATURATE_EN.
5. Stream of 8 random beats, out_ready low for 3 cycles mid-stream -> in_ready low in exactly those cycles (after out_valid), s/o/ovf held stable, all 8 results match the model in order.
6. Two beats in flight, rst_n pulsed low for 1 cycle asynchronously -> out_valid=0 and s=0 immediately, no result for the pre-reset beats appears, next accepted beat completes normally after 4 cycles.

Source files
------------

// File: rtl/pipe_addsub.sv
// pipe_addsub: pipelined WIDTH-bit adder/subtractor with carry/borrow-in.
//
// The operation is split into STAGES ripple slices of WIDTH/STAGES bits each,
// with a register after every slice. Slice k adds bits [k*SW +: SW] of a and
// b_eff plus the registered carry from slice k-1. Each beat carries its own
// sub flag and carry-in with it, so changing them between beats does not
// affect beats already in the pipeline.
//
// Each stage has one WIDTH-bit "x" register. Below the current slice it
// holds the finished result slices; at and above the current slice it still
// holds the not-yet-used bits of operand a. A separate "y" register carries
// b_eff, and only the upper part of y is consumed. The last stage reads
// a's MSB from the top of x. The saturation logic uses that bit.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake (in_ready = ~out_valid | out_ready)
//   a, b, d, sub        operands, carry/borrow-in, 0=add / 1=subtract
//   out_valid/out_ready result handshake
//   s, o, ovf           result, carry-out (add) / borrow-out (sub), signed overflow
//
// Optional build macro: PIPE_ADDSUB_SATURATE_EN. When it is defined, s is
// clamped to the signed limit whenever ovf=1. The o and ovf outputs always
// report the raw, unsaturated result.
module pipe_addsub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             d,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             o,
    output logic             ovf
);

    localparam int SW = WIDTH / STAGES;
    // The last stage never needs a y register. Keep at least one entry so the
    // declaration stays legal when STAGES=1.
    localparam int YN = (STAGES > 1) ? STAGES - 1 : 1;

    logic en;

    // Inputs to each stage: the ports for stage 0, otherwise the previous registers.
    logic [STAGES-1:0]            v_in, c_in, sub_in;
    logic [STAGES-1:0][WIDTH-1:0] x_in, y_in;

    // Stage registers.
    logic [STAGES-1:0]            v_q, c_q, sub_q;
    logic [STAGES-1:0][WIDTH-1:0] x_q;
    logic [YN-1:0][WIDTH-1:0]     y_q;
    logic                         ovf_q;

    // The whole pipeline advances together. It freezes only while the output
    // holds a beat that downstream is not accepting.
    assign en       = ~v_q[STAGES-1] | out_ready;
    assign in_ready = en;

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        logic [SW-1:0]    sa, sb;
        logic [SW:0]      full;
        logic [WIDTH-1:0] x_sum, x_d;

        if (k == 0) begin : g_head
            assign v_in[0]   = in_valid;
            assign x_in[0]   = a;
            assign y_in[0]   = sub ? ~b : b;
            assign c_in[0]   = sub ? ~d : d;
            assign sub_in[0] = sub;
        end else begin : g_link
            assign v_in[k]   = v_q[k-1];
            assign x_in[k]   = x_q[k-1];
            assign y_in[k]   = y_q[k-1];
            assign c_in[k]   = c_q[k-1];
            assign sub_in[k] = sub_q[k-1];
        end

        assign sa   = x_in[k][k*SW +: SW];
        assign sb   = SW'(y_in[k] >> (k*SW));
        assign full = {1'b0, sa} + {1'b0, sb} + {{SW{1'b0}}, c_in[k]};

        // Write this slice's sum over the operand bits it consumed.
        always_comb begin
            x_sum                = x_in[k];
            x_sum[k*SW +: SW]    = full[SW-1:0];
        end

        if (k == STAGES - 1) begin : g_last
            logic ovf_d;
            // Overflow = carry into MSB ^ carry out of MSB. The carry into the
            // MSB is recovered from the MSB sum bit.
            assign ovf_d = sa[SW-1] ^ sb[SW-1] ^ full[SW-1] ^ full[SW];
`ifdef PIPE_ADDSUB_SATURATE_EN
            localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
            localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
            // The top of x_in still holds operand a's top slice, so its MSB is a's sign.
            assign x_d = ovf_d ? (x_in[k][WIDTH-1] ? SMIN : SMAX) : x_sum;
`else
            assign x_d = x_sum;
`endif
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    ovf_q <= 1'b0;
                else if (en && v_in[k])
                    ovf_q <= ovf_d;
            end
        end else begin : g_mid
            assign x_d = x_sum;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    y_q[k] <= '0;
                else if (en && v_in[k])
                    y_q[k] <= y_in[k];
            end
        end

        // Data registers load only for real beats. Bubbles move through the
        // valid bits and leave the data registers unchanged.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q[k]   <= 1'b0;
                x_q[k]   <= '0;
                c_q[k]   <= 1'b0;
                sub_q[k] <= 1'b0;
            end else if (en) begin
                v_q[k] <= v_in[k];
                if (v_in[k]) begin
                    x_q[k]   <= x_d;
                    c_q[k]   <= full[SW];
                    sub_q[k] <= sub_in[k];
                end
            end
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign s         = x_q[STAGES-1];
    // For a subtract, a final carry of 0 means a borrow occurred.
    assign o         = c_q[STAGES-1] ^ sub_q[STAGES-1];
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipe_addsub.sv
module tb_pipe_addsub;
    localparam int W  = 16;
    localparam int ST = 4;
`ifdef PIPE_ADDSUB_SATURATE_EN
    localparam logic [W-1:0] OVF_S = 16'h7FFF;
`else
    localparam logic [W-1:0] OVF_S = 16'h8000;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready;
    logic [W-1:0] a, b;
    logic         d, sub;
    logic         out_valid, out_ready;
    logic [W-1:0] s;
    logic         o, ovf;

    int total = 0;
    int bad   = 0;

    logic [W+1:0] exp_q[$];   // {o, ovf, s}
    logic         hold_pend = 1'b0;
    logic [W+1:0] held;

    pipe_addsub #(.WIDTH(W), .STAGES(ST)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .d(d), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .o(o), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model built from plain full-width arithmetic.
    function automatic logic [W+1:0] model(input logic [W-1:0] aa, bb, input logic dd, ss);
        logic [W:0]   r;
        logic         ov;
        logic [W-1:0] sr;
        if (!ss) begin
            r  = {1'b0, aa} + {1'b0, bb} + 17'(dd);
            ov = (aa[W-1] == bb[W-1]) && (r[W-1] != aa[W-1]);
        end else begin
            r  = {1'b0, aa} - {1'b0, bb} - 17'(dd);
            ov = (aa[W-1] != bb[W-1]) && (r[W-1] != aa[W-1]);
        end
        sr = r[W-1:0];
`ifdef PIPE_ADDSUB_SATURATE_EN
        if (ov) sr = aa[W-1] ? 16'h8000 : 16'h7FFF;
`endif
        return {r[W], ov, sr};
    endfunction

    // Called at posedge+1. Returns at posedge+1 after the beat has been accepted.
    task automatic send(input logic [W-1:0] aa, bb, input logic dd, ss, input logic [W+1:0] e);
        int n = 0;
        in_valid = 1'b1; a = aa; b = bb; d = dd; sub = ss;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 100) begin
                chk("accept_timeout", 32'(n), 0);
                break;
            end
        end
        exp_q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 50);
    endtask

    task automatic drain;
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(exp_q.size()), 0);
        @(posedge clk); #1;
    endtask

    // Scoreboard: check each result as it leaves, and check that a stalled output stays stable.
    always @(negedge clk) begin
        logic [W+1:0] e;
        if (rst_n) begin
            if (hold_pend) chk("hold", {o, ovf, s}, held);
            hold_pend = out_valid && !out_ready;
            held      = {o, ovf, s};
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("spurious", 32'(out_valid), 0);
                else begin
                    e = exp_q.pop_front();
                    chk("s", s, e[W-1:0]);
                    chk("o", o, e[W+1]);
                    chk("ovf", ovf, e[W]);
                end
            end
        end
    end

    initial begin
        int lat;
        logic [W-1:0] ra, rb;
        logic         rd, rs;

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; d = 1'b0; sub = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_s", s, 0);
        chk("rst_o", 32'(o), 0);
        chk("rst_ovf", 32'(ovf), 0);
        rst_n = 1'b1;
        #1 chk("rst_in_ready", 32'(in_ready), 1);
        @(posedge clk); #1;

        // Latency of a single beat with no stall.
        send(16'h1234, 16'h4321, 1'b0, 1'b0, {1'b0, 1'b0, 16'h5555});
        wait_out(lat);
        chk("latency", 32'(lat), ST);
        drain();

        // Directed cases: carries across slice boundaries, borrows and overflow.
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 16'h0000});
        send(16'hFFFF, 16'h0000, 1'b1, 1'b0, {1'b1, 1'b0, 16'h0000});
        send(16'h0000, 16'h0001, 1'b0, 1'b1, {1'b1, 1'b0, 16'hFFFF});
        send(16'h8000, 16'h0001, 1'b0, 1'b1, {1'b0, 1'b1, 16'h7FFF});
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, OVF_S});
        send(16'h0005, 16'h0002, 1'b1, 1'b1, {1'b0, 1'b0, 16'h0002});
        send(16'h0003, 16'h0003, 1'b1, 1'b1, {1'b1, 1'b0, 16'hFFFF});
        drain();

        // Eight random beats back to back, with the output stalled for 3 cycles mid-stream.
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    ra = 16'($urandom); rb = 16'($urandom);
                    rd = 1'($urandom); rs = 1'($urandom);
                    send(ra, rb, rd, rs, model(ra, rb, rd, rs));
                end
            end
            begin
                repeat (6) @(posedge clk);
                #1 out_ready = 1'b0;
                for (int j = 0; j < 3; j++) begin
                    @(negedge clk);
                    chk("stall_out_valid", 32'(out_valid), 1);
                    chk("stall_in_ready", 32'(in_ready), 0);
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with two beats in flight, one of them stalled at the output.
        out_ready = 1'b0;
        send(16'h1111, 16'h2222, 1'b0, 1'b0, {1'b0, 1'b0, 16'h3333});
        send(16'hAAAA, 16'h1111, 1'b0, 1'b1, {1'b0, 1'b0, 16'h9999});
        repeat (4) @(posedge clk);
        #1 chk("pre_rst_valid", 32'(out_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 0);
        chk("arst_s", s, 0);
        exp_q.delete();
        hold_pend = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; out_ready = 1'b1;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            chk("no_stale", 32'(out_valid), 0);
        end
        @(posedge clk); #1;
        send(16'h00FF, 16'h0F01, 1'b0, 1'b0, {1'b0, 1'b0, 16'h1000});
        wait_out(lat);
        chk("post_rst_latency", 32'(lat), ST);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=%0d exp=0", 1);
        $fatal(1);
    end
endmodule
